// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add MUL and restoring DIVU/REMU, with valid/ready on both sides.
module alu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state, state_d;
  logic [WIDTH-1:0] res_d;
  logic [SHW-1:0]   cnt, cnt_d;
  logic [3:0]       op_q, op_d;
  // acc: MUL accumulator / division partial remainder
  // x:   MUL multiplicand / division dividend-then-quotient
  // y:   MUL multiplier / divisor
  logic [WIDTH-1:0] acc, acc_d, x, x_d, y, y_d;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             iter_op;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_quo;

  assign sh      = b[SHW-1:0];
  assign iter_op = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (b != '0));

  // One MUL step: add multiplicand when the current multiplier bit is set
  assign mul_acc = acc + (y[0] ? x : '0);

  // One restoring-division step on a WIDTH+1-bit partial remainder
  assign div_tmp = {acc, x[WIDTH-1]};
  assign div_ge  = (div_tmp >= {1'b0, y});
  assign div_rem = div_ge ? (div_tmp - {1'b0, y}) : div_tmp;
  assign div_quo = {x[WIDTH-2:0], div_ge};

  // Single-cycle result, computed from the inputs at the accept edge
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SRL:  alu_res = a >> sh;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLL:  alu_res = a << sh;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> sh);
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_DIVU: alu_res = '1;  // only reached with b == 0
      OP_REMU: alu_res = a;   // only reached with b == 0
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    res_d   = res;
    cnt_d   = cnt;
    op_d    = op_q;
    acc_d   = acc;
    x_d     = x;
    y_d     = y;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (iter_op) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            x_d     = a;
            y_d     = b;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt + SHW'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          x_d   = x << 1;
          y_d   = y >> 1;
        end else begin
          acc_d = div_rem[WIDTH-1:0];
          x_d   = div_quo;
        end
        if (cnt == SHW'(WIDTH - 1)) begin
          state_d = S_DONE;
          if (op_q == OP_MUL)       res_d = mul_acc;
          else if (op_q == OP_DIVU) res_d = div_quo;
          else                      res_d = div_rem[WIDTH-1:0];
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      res   <= '0;
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_d;
      res   <= res_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      acc   <= acc_d;
      x     <= x_d;
      y     <= y_d;
    end
  end

  // Handshake/status flags decoded straight from the state register
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_BUSY);
  assign out_valid = (state == S_DONE);
  assign zero      = (res == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter with an expected-result scoreboard.
module tb_alu_iter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_res_q[$];
  int               exp_lat_q[$];

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one op; lat is the number of clock edges after the accept edge
  // before out_valid is seen (0 for single-cycle ops, WIDTH for iterative).
  // hold = cycles to keep out_ready low in DONE while scrambling inputs.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] er,
                        input int el, input int hold);
    int lat;
    int busy_cyc;
    logic [WIDTH-1:0] er_q;
    int el_q;
    @(negedge clk);
    check({tag, " in_ready idle"}, WIDTH'(in_ready), WIDTH'(1));
    in_valid = 1'b1; op = o; a = x; b = y;
    exp_res_q.push_back(er);
    exp_lat_q.push_back(el);
    @(posedge clk);
    #1 in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 0;
    busy_cyc = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      if (busy && !in_ready) busy_cyc++;
      lat++;
      @(negedge clk);
    end
    er_q = exp_res_q.pop_front();
    el_q = exp_lat_q.pop_front();
    check({tag, " res"}, res, er_q);
    check({tag, " zero"}, WIDTH'(zero), WIDTH'(er_q == '0));
    check({tag, " latency"}, WIDTH'(lat), WIDTH'(el_q));
    if (el_q > 0) check({tag, " busy cycles"}, WIDTH'(busy_cyc), WIDTH'(el_q));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      check({tag, " hold res"}, res, er_q);
      check({tag, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " back to idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset flags", {28'd0, in_ready, out_valid, busy, zero}, 32'h9);
    check("reset res", res, '0);
    rst_n = 1'b1;

    run_op("ADD ovf",   4'h2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0);
    run_op("SUB 5-5",   4'h6, 32'd5,         32'd5,         32'h0,         0, 0);
    run_op("SLT",       4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0);
    run_op("SLTU",      4'hA, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0);
    run_op("SRA",       4'h9, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 0);
    run_op("SRL b=36",  4'h5, 32'h8000_0000, 32'd36,        32'h0800_0000, 0, 0);
    run_op("SLL",       4'h8, 32'h1,         32'd31,        32'h8000_0000, 0, 0);
    run_op("AND",       4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0);
    run_op("NOR",       4'h4, 32'hF0F0_0000, 32'h0000_000F, 32'h0F0F_FFF0, 0, 0);
    run_op("RSVD E",    4'hE, 32'h1234_5678, 32'h9,         32'h0,         0, 0);
    run_op("MUL",       4'hB, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, WIDTH, 0);
    run_op("MUL -1*-1", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         WIDTH, 0);
    run_op("DIVU",      4'hC, 32'd100,       32'd7,         32'd14,        WIDTH, 0);
    run_op("REMU",      4'hD, 32'd100,       32'd7,         32'd2,         WIDTH, 0);
    run_op("DIVU /0",   4'hC, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("REMU /0",   4'hD, 32'd5,         32'd0,         32'd5,         0, 0);
    run_op("backpress", 4'h3, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 0, 5);

    // Asynchronous reset in the middle of a MUL; the op is discarded
    @(negedge clk);
    in_valid = 1'b1; op = 4'hB; a = 32'h1234; b = 32'h5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid-MUL busy", WIDTH'(busy), WIDTH'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async rst flags", {28'd0, in_ready, out_valid, busy, zero}, 32'h9);
    check("async rst res", res, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("ADD after rst", 4'h2, 32'd2, 32'd3, 32'd5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
